// File: rtl/crc_stream_engine_if.sv
// Stream-in / result-out bundle for crc_stream_engine.
// The master drives frames and consumes results; the slave is the engine.
interface crc_stream_engine_if #(
  parameter int CRC_W  = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
);
  localparam int NB_W = $clog2(DATA_W / 8) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              in_eof;
  logic [NB_W-1:0]   in_nbytes;
  logic [CRC_W-1:0]  crc_expect;

  logic              res_valid;
  logic              res_ready;
  logic [CRC_W-1:0]  res_crc;
  logic [LEN_W-1:0]  res_len;
  logic              res_match;

  modport master (
    output in_valid, in_data, in_sof, in_eof, in_nbytes, crc_expect, res_ready,
    input  in_ready, res_valid, res_crc, res_len, res_match
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eof, in_nbytes, crc_expect, res_ready,
    output in_ready, res_valid, res_crc, res_len, res_match
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Parametrised streaming CRC generator/checker.
// Consumes one beat per clock (MSB byte first), folds the whole beat into the
// CRC register combinationally, and holds each frame's result until taken.
module crc_stream_engine #(
  parameter int               CRC_W       = 16,
  parameter int               DATA_W      = 16,
  parameter logic [CRC_W-1:0] POLY        = 'h1021,
  parameter logic [CRC_W-1:0] INIT        = 'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT     = 'h0000,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter int               LEN_W       = 16
) (
  input logic                clk,
  input logic                reset_n,
  crc_stream_engine_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int NB_W  = $clog2(BYTES) + 1;
  localparam int SUM_W = LEN_W + NB_W;
  localparam logic [SUM_W-1:0] LEN_MAX = SUM_W'({LEN_W{1'b1}});

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t           state_q;
  logic [CRC_W-1:0] crc_q;
  logic [LEN_W-1:0] len_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic [CRC_W-1:0] res_crc_q;
  logic [LEN_W-1:0] res_len_q;
  logic             res_match_q;

  logic             accept;
  logic             start;
  logic [NB_W-1:0]  nb_eff;
  logic [CRC_W-1:0] crc_base;
  logic [LEN_W-1:0] len_base;
  logic [CRC_W-1:0] crc_next;
  logic [SUM_W-1:0] len_sum;
  logic [LEN_W-1:0] len_next;
  logic [CRC_W-1:0] crc_final;

  // Fold the first n bytes of a beat (MSB byte first) into the register,
  // one bit at a time with the shift-and-conditional-XOR rule.
  function automatic logic [CRC_W-1:0] crc_bytes(input logic [CRC_W-1:0] c_in,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [NB_W-1:0]   n);
    logic [CRC_W-1:0] c;
    logic [7:0]       b;
    logic             fb;
    c = c_in;
    for (int i = 0; i < BYTES; i++) begin
      b = d[DATA_W-1-8*i -: 8];
      if (i < int'(n)) begin
        for (int k = 0; k < 8; k++) begin
          fb = c[CRC_W-1] ^ (REFLECT_IN ? b[k] : b[7-k]);
          c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] bit_reverse(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r;
  endfunction

  assign accept        = bus.in_valid && in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_crc   = res_crc_q;
  assign bus.res_len   = res_len_q;
  assign bus.res_match = res_match_q;

  // Per-beat datapath: pick the frame start values, the byte count, and the
  // CRC / length after this beat, plus the finished CRC for an eof beat.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    start     = (state_q == IDLE) || bus.in_sof;
    nb_eff    = NB_W'(BYTES);
    crc_base  = crc_q;
    len_base  = len_q;
    if (bus.in_eof && (bus.in_nbytes != '0) && (bus.in_nbytes <= NB_W'(BYTES)))
      nb_eff = bus.in_nbytes;
    if (start) begin
      crc_base = INIT;
      len_base = '0;
    end
    crc_next  = crc_bytes(crc_base, bus.in_data, nb_eff);
    len_sum   = SUM_W'(len_base) + SUM_W'(nb_eff);
    len_next  = (len_sum > LEN_MAX) ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    crc_final = (REFLECT_OUT ? bit_reverse(crc_next) : crc_next) ^ XOR_OUT;
  end

  // Frame FSM: accumulate beats, latch the result on eof, hold it until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!reset_n) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      len_q       <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_crc_q   <= '0;
      res_len_q   <= '0;
      res_match_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (bus.in_eof) begin
              state_q     <= RESULT;
              crc_q       <= INIT;
              len_q       <= '0;
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              res_crc_q   <= crc_final;
              res_len_q   <= len_next;
              res_match_q <= (crc_final == bus.crc_expect);
            end else begin
              state_q <= ACCUM;
              crc_q   <= crc_next;
              len_q   <= len_next;
            end
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomised scoreboard bench for crc_stream_engine: three instances cover the
// default CCITT engine, a reflected CRC-16/ARC with a short length counter,
// and a 32-bit-wide CRC-32 engine.
module tb_crc_stream_engine;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [31:0] crc;
    int          len;
    bit          match;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  bit   hold0  = 1'b0;
  bit   rand0  = 1'b0;
  exp_t q0[$], q1[$], q2[$];
  bq_t  s9;

  always #5 clk = ~clk;

  crc_stream_engine_if #(.CRC_W(16), .DATA_W(16), .LEN_W(16)) b0();
  crc_stream_engine_if #(.CRC_W(16), .DATA_W(16), .LEN_W(4))  b1();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(32), .LEN_W(16)) b2();

  crc_stream_engine u0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));

  crc_stream_engine #(
    .CRC_W(16), .DATA_W(16), .POLY(16'h8005), .INIT(16'h0000), .XOR_OUT(16'h0000),
    .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .LEN_W(4)
  ) u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));

  crc_stream_engine #(
    .CRC_W(32), .DATA_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .LEN_W(16)
  ) u2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC: textbook byte-at-a-time form over a byte queue.
  function automatic logic [31:0] ref_crc(input bq_t data, input int w,
                                          input logic [31:0] poly, input logic [31:0] init,
                                          input logic [31:0] xorout, input bit refin,
                                          input bit refout);
    logic [63:0] c, mask, r;
    logic [7:0]  b, rb;
    mask = (64'd1 << w) - 64'd1;
    c    = {32'd0, init} & mask;
    foreach (data[i]) begin
      b = data[i];
      for (int k = 0; k < 8; k++) rb[k] = b[7-k];
      if (refin) b = rb;
      c = c ^ (64'(b) << (w - 8));
      repeat (8) c = c[w-1] ? (((c << 1) ^ {32'd0, poly}) & mask) : ((c << 1) & mask);
    end
    if (refout) begin
      r = '0;
      for (int k = 0; k < w; k++) r[k] = c[w-1-k];
      c = r;
    end
    return 32'((c ^ {32'd0, xorout}) & mask);
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    repeat (n) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic logic [31:0] ccitt(input bq_t d);
    return ref_crc(d, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
  endfunction

  // Result monitors: pop the oldest expectation whenever a result handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && b0.res_valid && b0.res_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0 unexpected result: crc=%0h with empty scoreboard", b0.res_crc);
      end else begin
        e = q0.pop_front();
        check("u0 res_crc", b0.res_crc, e.crc);
        check("u0 res_len", b0.res_len, e.len);
        check("u0 res_match", b0.res_match, e.match);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && b1.res_valid && b1.res_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 unexpected result: crc=%0h with empty scoreboard", b1.res_crc);
      end else begin
        e = q1.pop_front();
        check("u1 res_crc", b1.res_crc, e.crc);
        check("u1 res_len", b1.res_len, e.len);
        check("u1 res_match", b1.res_match, e.match);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && b2.res_valid && b2.res_ready) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL u2 unexpected result: crc=%0h with empty scoreboard", b2.res_crc);
      end else begin
        e = q2.pop_front();
        check("u2 res_crc", b2.res_crc, e.crc);
        check("u2 res_len", b2.res_len, e.len);
        check("u2 res_match", b2.res_match, e.match);
      end
    end
  end

  // Result back-pressure for u0: held low on request, random in the random phase.
  always @(posedge clk) begin
    #1;
    b0.res_ready = hold0 ? 1'b0 : (rand0 ? ($urandom_range(3) != 0) : 1'b1);
  end

  task automatic send0(input logic [15:0] d, input bit sof, input bit eof,
                       input logic [1:0] nb, input logic [15:0] cexp);
    int n;
    n = 0;
    b0.in_valid = 1'b1; b0.in_data = d; b0.in_sof = sof; b0.in_eof = eof;
    b0.in_nbytes = nb; b0.crc_expect = cexp;
    @(negedge clk);
    while (!b0.in_ready && n < 200) begin n++; @(negedge clk); end
    if (!b0.in_ready) begin
      checks++; errors++;
      $display("FAIL u0 in_ready timeout: got %0b expected 1", b0.in_ready);
    end
    @(posedge clk); #1;
    b0.in_valid = 1'b0; b0.in_sof = 1'b0; b0.in_eof = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d, input bit sof, input bit eof,
                       input logic [1:0] nb, input logic [15:0] cexp);
    int n;
    n = 0;
    b1.in_valid = 1'b1; b1.in_data = d; b1.in_sof = sof; b1.in_eof = eof;
    b1.in_nbytes = nb; b1.crc_expect = cexp;
    @(negedge clk);
    while (!b1.in_ready && n < 200) begin n++; @(negedge clk); end
    if (!b1.in_ready) begin
      checks++; errors++;
      $display("FAIL u1 in_ready timeout: got %0b expected 1", b1.in_ready);
    end
    @(posedge clk); #1;
    b1.in_valid = 1'b0; b1.in_sof = 1'b0; b1.in_eof = 1'b0;
  endtask

  task automatic send2(input logic [31:0] d, input bit sof, input bit eof,
                       input logic [2:0] nb, input logic [31:0] cexp);
    int n;
    n = 0;
    b2.in_valid = 1'b1; b2.in_data = d; b2.in_sof = sof; b2.in_eof = eof;
    b2.in_nbytes = nb; b2.crc_expect = cexp;
    @(negedge clk);
    while (!b2.in_ready && n < 200) begin n++; @(negedge clk); end
    if (!b2.in_ready) begin
      checks++; errors++;
      $display("FAIL u2 in_ready timeout: got %0b expected 1", b2.in_ready);
    end
    @(posedge clk); #1;
    b2.in_valid = 1'b0; b2.in_sof = 1'b0; b2.in_eof = 1'b0;
  endtask

  // u0 frame: optional two-beat discarded prefix, then the frame in 2-byte beats.
  task automatic frame0(input bq_t d, input bit garbage, input bit sof_exp,
                        input logic [15:0] cexp, input logic [15:0] expcrc);
    exp_t e;
    int   rem;
    logic [1:0] nb;
    e.crc = 32'(expcrc);
    e.len = (d.size() > 65535) ? 65535 : d.size();
    e.match = (expcrc == cexp);
    q0.push_back(e);
    if (garbage) begin
      send0(16'($urandom), 1'b1, 1'b0, 2'($urandom), 16'($urandom));
      send0(16'($urandom), 1'b0, 1'b0, 2'($urandom), 16'($urandom));
    end
    for (int i = 0; i < d.size(); i += 2) begin
      rem = d.size() - i;
      if (rem == 1) nb = 2'd1;
      else if (rem == 2) nb = ($urandom_range(2) == 0) ? 2'd0 : (($urandom_range(1) == 0) ? 2'd2 : 2'd3);
      else nb = 2'($urandom);
      send0({d[i], (rem > 1) ? d[i+1] : 8'($urandom)}, (i == 0) && (sof_exp || garbage),
            rem <= 2, nb, cexp);
    end
  endtask

  task automatic frame1(input bq_t d, input logic [15:0] cexp, input logic [15:0] expcrc);
    exp_t e;
    int   rem;
    e.crc = 32'(expcrc);
    e.len = (d.size() > 15) ? 15 : d.size();
    e.match = (expcrc == cexp);
    q1.push_back(e);
    for (int i = 0; i < d.size(); i += 2) begin
      rem = d.size() - i;
      send1({d[i], (rem > 1) ? d[i+1] : 8'($urandom)}, i == 0, rem <= 2,
            (rem >= 2) ? 2'd2 : 2'd1, cexp);
    end
  endtask

  task automatic frame2(input bq_t d, input logic [31:0] cexp, input logic [31:0] expcrc);
    exp_t e;
    int   rem;
    logic [31:0] beat;
    logic [2:0]  nb;
    e.crc = expcrc;
    e.len = d.size();
    e.match = (expcrc == cexp);
    q2.push_back(e);
    for (int i = 0; i < d.size(); i += 4) begin
      rem = d.size() - i;
      for (int j = 0; j < 4; j++) beat[31-8*j -: 8] = (i + j < d.size()) ? d[i+j] : 8'($urandom);
      nb = (rem >= 4) ? (($urandom_range(1) == 0) ? 3'd0 : 3'(4 + $urandom_range(3))) : 3'(rem);
      send2(beat, i == 0, rem <= 4, nb, cexp);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 2000) begin
      @(posedge clk); n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      checks++; errors++;
      $display("FAIL drain timeout: %0d results outstanding, expected 0",
               q0.size() + q1.size() + q2.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_res0();
    int n;
    n = 0;
    while (!b0.res_valid && n < 200) begin @(negedge clk); n++; end
    check("u0 res_valid wait", b0.res_valid, 1'b1);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, " in_ready"}, b0.in_ready, 1'b1);
    check({tag, " res_valid"}, b0.res_valid, 1'b0);
    check({tag, " res_crc"}, b0.res_crc, 16'h0);
    check({tag, " res_len"}, b0.res_len, 16'h0);
    check({tag, " res_match"}, b0.res_match, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t d;
    logic [31:0] c;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    {b0.in_valid, b0.in_sof, b0.in_eof} = '0;
    {b1.in_valid, b1.in_sof, b1.in_eof} = '0;
    {b2.in_valid, b2.in_sof, b2.in_eof} = '0;
    b0.in_data = '0; b0.in_nbytes = '0; b0.crc_expect = '0;
    b1.in_data = '0; b1.in_nbytes = '0; b1.crc_expect = '0;
    b2.in_data = '0; b2.in_nbytes = '0; b2.crc_expect = '0;
    b1.res_ready = 1'b1;
    b2.res_ready = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset0("reset");
    check("u2 reset in_ready", b2.in_ready, 1'b1);
    check("u2 reset res_crc", b2.res_crc, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // CRC-16/ARC and CRC-32 check values, then random frames on the same engines
    frame1(s9, 16'hBB3D, 16'hBB3D);
    d = rand_bytes(20);
    c = ref_crc(d, 16, 32'h8005, 32'h0, 32'h0, 1'b1, 1'b1);
    frame1(d, c[15:0], c[15:0]);
    frame2(s9, 32'hCBF43926, 32'hCBF43926);
    d = rand_bytes(7);
    c = ref_crc(d, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    frame2(d, c ^ 32'h1, c);
    wait_drain();

    // Default engine: "123456789" with a one-byte eof beat
    frame0(s9, 1'b0, 1'b1, 16'h29B1, 16'h29B1);
    wait_drain();

    // Result held for 5 cycles; offered beats must be ignored
    hold0 = 1'b1;
    frame0(s9, 1'b0, 1'b0, 16'h1234, 16'h29B1);
    wait_res0();
    b0.in_valid = 1'b1; b0.in_sof = 1'b1; b0.in_eof = 1'b1;
    b0.in_data = 16'($urandom); b0.in_nbytes = 2'd2;
    repeat (5) begin
      @(negedge clk);
      check("hold in_ready", b0.in_ready, 1'b0);
      check("hold res_valid", b0.res_valid, 1'b1);
      check("hold res_crc", b0.res_crc, 16'h29B1);
      check("hold res_len", b0.res_len, 16'd9);
      check("hold res_match", b0.res_match, 1'b0);
    end
    @(posedge clk); #1;
    b0.in_valid = 1'b0; b0.in_sof = 1'b0; b0.in_eof = 1'b0;
    hold0 = 1'b0;
    d = rand_bytes(5);
    c = ccitt(d);
    frame0(d, 1'b0, 1'b1, c[15:0], c[15:0]);
    wait_drain();

    // Mid-frame sof discards the garbage prefix; match and mismatch
    frame0(s9, 1'b1, 1'b1, 16'h29B1, 16'h29B1);
    frame0(s9, 1'b1, 1'b1, 16'h29B0, 16'h29B1);
    wait_drain();

    // Reset mid-frame
    send0(16'h3132, 1'b1, 1'b0, 2'd0, 16'h0);
    send0(16'h3334, 1'b0, 1'b0, 2'd0, 16'h0);
    reset_n = 1'b0;
    #1 check_reset0("reset mid-frame");
    @(posedge clk); #1 reset_n = 1'b1;
    frame0(s9, 1'b0, 1'b0, 16'h29B1, 16'h29B1);
    wait_drain();

    // Reset with a result pending
    hold0 = 1'b1;
    d = rand_bytes(6);
    c = ccitt(d);
    frame0(d, 1'b0, 1'b1, c[15:0], c[15:0]);
    wait_res0();
    reset_n = 1'b0;
    q0.delete();
    #1 check_reset0("reset pending");
    @(posedge clk); #1 reset_n = 1'b1;
    hold0 = 1'b0;
    frame0(s9, 1'b0, 1'b1, 16'h29B1, 16'h29B1);
    wait_drain();

    // Random frames with random back-pressure, prefixes, sof style and match
    rand0 = 1'b1;
    repeat (40) begin
      bit garbage;
      bit match;
      d = rand_bytes($urandom_range(12, 1));
      c = ccitt(d);
      garbage = ($urandom_range(4) == 0);
      match = $urandom_range(1) != 0;
      frame0(d, garbage, $urandom_range(1) != 0,
             match ? c[15:0] : (c[15:0] ^ (16'd1 << $urandom_range(15))), c[15:0]);
    end
    rand0 = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
